// File: rtl/bp_hazard_unit_if.sv
// ============================================================================
// Module      : bp_hazard_unit_if
// Description : IF/EX-side bundle for the branch predictor / hazard unit.
//               Perf-counter outputs exist only with BP_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_hazard_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_IF;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic [6:0]      op_ex;
    logic [XLEN-1:0] pc_EX;
    logic            pred_taken_EX;
    logic [XLEN-1:0] pred_target_EX;
    logic            PCSel_EX;
    logic [XLEN-1:0] alu;
    logic [4:0]      rd_EX;
    logic [4:0]      rs1_ID;
    logic [4:0]      rs2_ID;
    logic            stall_PC;
    logic            stall_ID;
    logic            flush_ID_EX;
    logic            flush_IF_ID;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
`ifdef BP_PERF_CNT_EN
    logic [31:0]     br_cnt_o;
    logic [31:0]     mispred_cnt_o;
`endif

    modport master (
        output pc_IF, op_ex, pc_EX, pred_taken_EX, pred_target_EX,
               PCSel_EX, alu, rd_EX, rs1_ID, rs2_ID,
        input  pred_taken_o, pred_target_o, stall_PC, stall_ID,
               flush_ID_EX, flush_IF_ID, redirect_o, redirect_pc_o
`ifdef BP_PERF_CNT_EN
        , input br_cnt_o, mispred_cnt_o
`endif
    );

    modport slave (
        input  pc_IF, op_ex, pc_EX, pred_taken_EX, pred_target_EX,
               PCSel_EX, alu, rd_EX, rs1_ID, rs2_ID,
        output pred_taken_o, pred_target_o, stall_PC, stall_ID,
               flush_ID_EX, flush_IF_ID, redirect_o, redirect_pc_o
`ifdef BP_PERF_CNT_EN
        , output br_cnt_o, mispred_cnt_o
`endif
    );
endinterface

`default_nettype wire

// File: rtl/bp_hazard_unit.sv
// ============================================================================
// Module      : bp_hazard_unit
// Description : Direct-mapped counter/BTB predictor, EX branch resolution and
//               load-use hazard control. Optional macro: BP_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_hazard_unit #(
    parameter int XLEN        = 32,
    parameter int NUM_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bp_hazard_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_WT  = c_CNT_ONE << (CNT_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_WNT = c_CNT_WT - c_CNT_ONE;
    localparam logic [XLEN-1:0]  c_FOUR    = XLEN'(4);

    logic [CNT_W-1:0] r_cnt    [NUM_ENTRIES];
    logic             r_valid  [NUM_ENTRIES];
    logic [TAG_W-1:0] r_tag    [NUM_ENTRIES];
    logic [XLEN-1:0]  r_target [NUM_ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_hit;
    logic             w_ex_hit;
    logic             w_ctrl;
    logic             w_mispred;
    logic             w_load_use;
    logic             w_unused;

    assign w_if_idx = bus.pc_IF[IDX_W+1:2];
    assign w_if_tag = bus.pc_IF[XLEN-1:IDX_W+2];
    assign w_ex_idx = bus.pc_EX[IDX_W+1:2];
    assign w_ex_tag = bus.pc_EX[XLEN-1:IDX_W+2];
    assign w_unused = ^{bus.pc_IF[1:0], bus.pc_EX[1:0]};

    // Prediction reads the table before this cycle's update lands (no bypass).
    assign w_hit              = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bus.pred_taken_o   = w_hit && r_cnt[w_if_idx][CNT_W-1];
    assign bus.pred_target_o  = bus.pred_taken_o ? r_target[w_if_idx]
                                                 : bus.pc_IF + c_FOUR;

    assign w_ctrl     = (bus.op_ex[6:4] == 3'b110);
    assign w_mispred  = w_ctrl && ((bus.PCSel_EX != bus.pred_taken_EX) ||
                        (bus.PCSel_EX && (bus.alu != bus.pred_target_EX)));
    assign w_load_use = (bus.op_ex == 7'b0000011) && (bus.rd_EX != 5'd0) &&
                        ((bus.rd_EX == bus.rs1_ID) || (bus.rd_EX == bus.rs2_ID));

    assign bus.redirect_o    = w_mispred;
    assign bus.redirect_pc_o = bus.PCSel_EX ? bus.alu : bus.pc_EX + c_FOUR;
    assign bus.flush_IF_ID   = w_mispred;
    assign bus.flush_ID_EX   = w_mispred | w_load_use;
    assign bus.stall_PC      = w_load_use & ~w_mispred;
    assign bus.stall_ID      = w_load_use & ~w_mispred;

    // A taken update that does not hit an existing valid entry allocates it
    // fresh at weakly-taken instead of nudging a stale counter.
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cnt[i]    <= c_CNT_WNT;
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (w_ctrl) begin
            if (bus.PCSel_EX) begin
                if (!w_ex_hit) begin
                    r_cnt[w_ex_idx] <= c_CNT_WT;
                end else if (r_cnt[w_ex_idx] != c_CNT_MAX) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + c_CNT_ONE;
                end
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= bus.alu;
            end else if (r_cnt[w_ex_idx] != '0) begin
                r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - c_CNT_ONE;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_ctrl)    r_br_cnt      <= r_br_cnt + 32'd1;
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign bus.br_cnt_o      = r_br_cnt;
    assign bus.mispred_cnt_o = r_mispred_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/bp_hazard_unit.md
# bp_hazard_unit

Parametrised hazard and branch-prediction unit for the 5-stage RV32 pipeline. It provides IF-stage next-PC prediction from a direct-mapped table of saturating counters with a tagged branch target buffer. In EX it resolves branches against the prediction carried down the pipe and raises redirect/flush on mispredict. It also detects load-use hazards and generates the PC/IF-ID stall and the ID/EX bubble.

## Interface
Parameters:
- XLEN, 32, datapath/PC width.
- NUM_ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = log2(NUM_ENTRIES).
- CNT_W, 2, saturating counter width, 1..4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_IF  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  IF prediction: redirect fetch.
- pred_target_o  out  XLEN  predicted next PC.
- op_ex  in  7  opcode of instruction in EX.
- pc_EX  in  XLEN  PC of instruction in EX.
- pred_taken_EX  in  1  prediction made for it in IF, piped down.
- pred_target_EX  in  XLEN  predicted target, piped down.
- PCSel_EX  in  1  resolved taken.
- alu  in  XLEN  resolved target.
- rd_EX, rs1_ID, rs2_ID  in  5  register indices.
- stall_PC, stall_ID, flush_ID_EX, flush_IF_ID  out  1  pipeline control.
- redirect_o  out  1  mispredict: load redirect_pc_o into PC.
- redirect_pc_o  out  XLEN  corrected PC.
- br_cnt_o, mispred_cnt_o  out  32  resolved-branch / mispredict counts (BP_PERF_CNT_EN only).

## Operation
- idx(pc) = pc[IDX_W+1:2]; tag(pc) = pc[XLEN-1:IDX_W+2].
- State per entry: CNT_W-bit counter, valid, tag, XLEN-bit target.
- Prediction (combinational read): hit = valid && tag match at idx(pc_IF). pred_taken_o = hit && counter MSB. pred_target_o = target if pred_taken_o, else pc_IF+4 (mod 2^XLEN).
- Control transfer in EX: op_ex[6:4]==3'b110 (BRANCH, JAL, JALR).
- mispredict = control transfer && (PCSel_EX != pred_taken_EX || (PCSel_EX && alu != pred_target_EX)).
- On mispredict: redirect_o=1, flush_IF_ID=1, flush_ID_EX=1. redirect_pc_o = PCSel_EX ? alu : pc_EX+4. redirect_pc_o is the same formula when redirect_o=0, so the value is don't-care there.
- Table update at idx(pc_EX) on the clock edge of every control transfer:
  - Counter increments (saturating at all-ones) if taken, decrements (saturating at 0) if not.
  - If taken: valid=1, tag=tag(pc_EX), target=alu. If not taken, tag/target/valid are untouched.
  - A tag mismatch on a taken update replaces the entry. The counter is reset to weakly-taken (2^(CNT_W-1)) rather than incremented.
- Load-use: op_ex==7'b0000011 && rd_EX!=0 && (rd_EX==rs1_ID || rd_EX==rs2_ID) gives stall_PC=stall_ID=flush_ID_EX=1.
- Priority: mispredict wins. Load and control-transfer opcodes are mutually exclusive, so this matters only for X/illegal op; when mispredict=1, stall_PC=stall_ID=0.
- All control outputs are 0 otherwise.

## Timing
- Stall/flush/redirect/prediction outputs are combinational, valid the same cycle as their inputs.
- Table write takes effect at the edge ending the EX cycle. A lookup of the same index in that cycle returns the old value. The next cycle sees the new value; there is no bypass.
- Reset (synchronous, any cycle, overrides a concurrent update):
  - All valid bits 0.
  - Counters weakly-not-taken (2^(CNT_W-1)-1; 0 when CNT_W=1).
  - Tags/targets 0.
  - Perf counters 0.
- With rst_i=1, pred_taken_o=0 follows from valid=0 in the cycle after the reset edge. Combinational control outputs track their inputs throughout.
- Perf counters wrap modulo 2^32.

## Configuration
- BP_PERF_CNT_EN defined:
  - br_cnt_o increments on every control transfer in EX.
  - mispred_cnt_o increments on every mispredict.
  - Both are registered and visible the cycle after the event.
- BP_PERF_CNT_EN undefined: both ports and counters are absent. Prediction and hazard behaviour is identical.

## Test plan
- Reset, then pc_IF=0x100 -> pred_taken_o=0, pred_target_o=0x104. All controls 0.
- Load-use: op_ex=0000011, rd_EX=5, rs2_ID=5 -> stall_PC=stall_ID=flush_ID_EX=1, flush_IF_ID=0. Same with rd_EX=0 -> all 0.
- Cold branch at pc_EX=0x200 taken to 0x240, pred_taken_EX=0 -> redirect_o=1, redirect_pc_o=0x240, both flushes=1. Next cycle pc_IF=0x200 -> pred_taken_o=1, pred_target_o=0x240.
- NUM_ENTRIES=16: alternate updates of PCs 0x200 and 0x240 (same index, different tag) taken -> entry replaced each time; lookup of the other PC misses.
- Counter saturation, CNT_W=2: five taken then one not-taken at 0x300 -> still predicts taken. Second not-taken -> predicts not-taken with target 0x304.
- JALR predicted taken to 0x400, resolved alu=0x408 -> mispredict, redirect_pc_o=0x408. With BP_PERF_CNT_EN: mispred_cnt_o +1, br_cnt_o +1 on the next cycle.
